// File: rtl/wb_pkg.sv
// Shared types and widths for the register-file writeback path.
package wb_pkg;

   localparam int unsigned REG_ADDR_W = 5;
   localparam int unsigned REG_DATA_W = 32;

   localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd31;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] addr;
      logic [REG_DATA_W-1:0] data;
   } wb_entry_t;

endpackage

// File: rtl/reg_wb_arbiter_if.sv
// Producer handshakes and register-file write port of the writeback arbiter.
interface reg_wb_arbiter_if;
   import wb_pkg::*;

   logic                  alu_valid;
   logic                  alu_ready;
   logic [REG_ADDR_W-1:0] alu_addr;
   logic [REG_DATA_W-1:0] alu_data;
   logic                  ld_valid;
   logic                  ld_ready;
   logic [REG_ADDR_W-1:0] ld_addr;
   logic [REG_DATA_W-1:0] ld_data;
   logic                  WriteEnable;
   logic [REG_ADDR_W-1:0] WriteAddr;
   logic [REG_DATA_W-1:0] WriteData;
   logic                  busy;

   modport master (
      output alu_valid, alu_addr, alu_data, ld_valid, ld_addr, ld_data,
      input  alu_ready, ld_ready, WriteEnable, WriteAddr, WriteData, busy
   );

   modport slave (
      input  alu_valid, alu_addr, alu_data, ld_valid, ld_addr, ld_data,
      output alu_ready, ld_ready, WriteEnable, WriteAddr, WriteData, busy
   );

endinterface

// File: rtl/wb_fifo.sv
// Synchronous per-source FIFO of writeback entries; head is visible while non-empty.
module wb_fifo
   import wb_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic      clk,
   input  logic      reset,
   input  logic      push,
   input  wb_entry_t pushEntry,
   input  logic      pop,
   output wb_entry_t headEntry,
   output logic      full,
   output logic      empty
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   wb_entry_t        mem [DEPTH];
   logic [PTR_W-1:0] wrPtr;
   logic [PTR_W-1:0] rdPtr;
   logic [CNT_W-1:0] count;
   logic             doPush;
   logic             doPop;

   assign full      = (count == CNT_W'(DEPTH));
   assign empty     = (count == '0);
   assign doPush    = push && !full;
   assign doPop     = pop && !empty;
   assign headEntry = mem[rdPtr];

   // Pointers wrap naturally; the extra count bit separates full from empty.
   always_ff @(posedge clk) begin
      if (reset) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else begin
         if (doPush) wrPtr <= wrPtr + PTR_W'(1);
         if (doPop)  rdPtr <= rdPtr + PTR_W'(1);
         count <= count + CNT_W'(doPush) - CNT_W'(doPop);
      end
   end

   always_ff @(posedge clk) begin
      if (doPush) mem[wrPtr] <= pushEntry;
   end

endmodule

// File: rtl/reg_wb_arbiter.sv
// Arbitrates ALU and load results onto the register-file write port, load first with ALU aging.
// Optional: define WB_R31_FILTER_EN to suppress write pulses to R31 (entries still drain).
module reg_wb_arbiter
   import wb_pkg::*;
#(
   parameter int unsigned DEPTH    = 2,
   parameter int unsigned MAX_WAIT = 4
) (
   input  logic             clk,
   input  logic             reset,
   reg_wb_arbiter_if.slave  bus
);

   localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

   wb_entry_t             aluHead;
   wb_entry_t             ldHead;
   wb_entry_t             grantEntry_c;
   logic                  aluFull, aluEmpty, ldFull, ldEmpty;
   logic                  aluPush, ldPush;
   logic                  aluGrant_c, ldGrant_c, writeGo_c;
   logic [WAIT_W-1:0]     aluWait;
   logic                  writeEnable;
   logic [REG_ADDR_W-1:0] writeAddr;
   logic [REG_DATA_W-1:0] writeData;

   assign bus.alu_ready = !aluFull && !reset;
   assign bus.ld_ready  = !ldFull && !reset;
   assign aluPush       = bus.alu_valid && bus.alu_ready;
   assign ldPush        = bus.ld_valid && bus.ld_ready;

   wb_fifo #(.DEPTH(DEPTH)) u_alu_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (aluPush),
      .pushEntry ({bus.alu_addr, bus.alu_data}),
      .pop       (aluGrant_c),
      .headEntry (aluHead),
      .full      (aluFull),
      .empty     (aluEmpty)
   );

   wb_fifo #(.DEPTH(DEPTH)) u_ld_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (ldPush),
      .pushEntry ({bus.ld_addr, bus.ld_data}),
      .pop       (ldGrant_c),
      .headEntry (ldHead),
      .full      (ldFull),
      .empty     (ldEmpty)
   );

   // Load wins unless the ALU head has waited MAX_WAIT cycles.
   always_comb begin
      aluGrant_c   = 1'b0;
      ldGrant_c    = 1'b0;
      grantEntry_c = ldHead;
      aluGrant_c   = !aluEmpty && (ldEmpty || (aluWait == WAIT_W'(MAX_WAIT)));
      ldGrant_c    = !ldEmpty && !aluGrant_c;
      if (aluGrant_c) grantEntry_c = aluHead;
`ifdef WB_R31_FILTER_EN
      writeGo_c = (aluGrant_c || ldGrant_c) && (grantEntry_c.addr != REG_ZERO);
`else
      writeGo_c = aluGrant_c || ldGrant_c;
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         aluWait     <= '0;
         writeEnable <= 1'b0;
         writeAddr   <= '0;
         writeData   <= '0;
      end else begin
         writeEnable <= writeGo_c;
         if (writeGo_c) begin
            writeAddr <= grantEntry_c.addr;
            writeData <= grantEntry_c.data;
         end
         if (aluGrant_c)
            aluWait <= '0;
         else if (!aluEmpty && (aluWait != WAIT_W'(MAX_WAIT)))
            aluWait <= aluWait + WAIT_W'(1);
      end
   end

   assign bus.WriteEnable = writeEnable;
   assign bus.WriteAddr   = writeAddr;
   assign bus.WriteData   = writeData;
   assign bus.busy        = !aluEmpty || !ldEmpty || writeEnable;

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Directed self-checking bench for reg_wb_arbiter (DEPTH=2, MAX_WAIT=4).
module tb_reg_wb_arbiter;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   nCmp = 0;
   int   nBad = 0;
   logic [36:0] wlog [$];

   reg_wb_arbiter_if bus ();

   reg_wb_arbiter #(.DEPTH(2), .MAX_WAIT(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Every write pulse seen on the register-file port, in order.
   always @(negedge clk) begin
      if (bus.WriteEnable === 1'b1) wlog.push_back({bus.WriteAddr, bus.WriteData});
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.alu_valid = 1'b0;
      bus.alu_addr  = '0;
      bus.alu_data  = '0;
      bus.ld_valid  = 1'b0;
      bus.ld_addr   = '0;
      bus.ld_data   = '0;
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 1'b1;
      step();
      step();
      nCmp++; if (bus.alu_ready !== 1'b0) begin nBad++; $display("FAIL rst_alu_ready: got %b expected 0", bus.alu_ready); end
      nCmp++; if (bus.ld_ready !== 1'b0) begin nBad++; $display("FAIL rst_ld_ready: got %b expected 0", bus.ld_ready); end
      nCmp++; if (bus.WriteEnable !== 1'b0) begin nBad++; $display("FAIL rst_we: got %b expected 0", bus.WriteEnable); end
      nCmp++; if (bus.WriteAddr !== 5'd0) begin nBad++; $display("FAIL rst_addr: got %h expected 00", bus.WriteAddr); end
      nCmp++; if (bus.WriteData !== 32'd0) begin nBad++; $display("FAIL rst_data: got %h expected 0", bus.WriteData); end
      nCmp++; if (bus.busy !== 1'b0) begin nBad++; $display("FAIL rst_busy: got %b expected 0", bus.busy); end
      reset = 1'b0;
      step();
      nCmp++; if (bus.alu_ready !== 1'b1) begin nBad++; $display("FAIL post_rst_alu_ready: got %b expected 1", bus.alu_ready); end
      nCmp++; if (bus.ld_ready !== 1'b1) begin nBad++; $display("FAIL post_rst_ld_ready: got %b expected 1", bus.ld_ready); end
   endtask

   task automatic test_single();
      wlog.delete();
      bus.alu_valid = 1'b1;
      bus.alu_addr  = 5'd3;
      bus.alu_data  = 32'hDEADBEEF;
      step();
      bus.alu_valid = 1'b0;
      nCmp++; if (bus.WriteEnable !== 1'b0) begin nBad++; $display("FAIL single_we_early: got %b expected 0", bus.WriteEnable); end
      nCmp++; if (bus.busy !== 1'b1) begin nBad++; $display("FAIL single_busy: got %b expected 1", bus.busy); end
      step();
      nCmp++; if (bus.WriteEnable !== 1'b1) begin nBad++; $display("FAIL single_we: got %b expected 1", bus.WriteEnable); end
      nCmp++; if (bus.WriteAddr !== 5'd3) begin nBad++; $display("FAIL single_addr: got %0d expected 3", bus.WriteAddr); end
      nCmp++; if (bus.WriteData !== 32'hDEADBEEF) begin nBad++; $display("FAIL single_data: got %h expected deadbeef", bus.WriteData); end
      step();
      nCmp++; if (bus.WriteEnable !== 1'b0) begin nBad++; $display("FAIL single_we_pulse: got %b expected 0", bus.WriteEnable); end
      nCmp++; if (bus.busy !== 1'b0) begin nBad++; $display("FAIL single_busy_end: got %b expected 0", bus.busy); end
   endtask

   task automatic test_priority();
      localparam int NL = 16;
      localparam int NA = 4;
      logic [36:0] expq [$];
      int li = 0, ai = 0;
      logic ldGo = 1'b0, aluGo = 1'b0, done = 1'b0;
      wlog.delete();
      for (int g = 0; g < NA; g++) begin
         for (int j = 0; j < 4; j++)
            expq.push_back({5'(g*4 + j + 1), 32'h1000_0000 + 32'(g*4 + j)});
         expq.push_back({5'(20 + g), 32'hA000_0000 + 32'(g)});
      end
      for (int c = 0; c < 200 && !done; c++) begin
         step();
         if (ldGo) li++;
         if (aluGo) ai++;
         if (li == NL && ai == NA && bus.busy === 1'b0) done = 1'b1;
         bus.ld_valid  = (li < NL);
         bus.ld_addr   = 5'(li + 1);
         bus.ld_data   = 32'h1000_0000 + 32'(li);
         bus.alu_valid = (ai < NA);
         bus.alu_addr  = 5'(20 + ai);
         bus.alu_data  = 32'hA000_0000 + 32'(ai);
         ldGo  = bus.ld_valid && bus.ld_ready;
         aluGo = bus.alu_valid && bus.alu_ready;
      end
      idle_inputs();
      nCmp++; if (!done) begin nBad++; $display("FAIL prio_timeout: got li=%0d ai=%0d expected %0d/%0d drained", li, ai, NL, NA); end
      nCmp++; if (wlog.size() != expq.size()) begin nBad++; $display("FAIL prio_count: got %0d expected %0d", wlog.size(), expq.size()); end
      for (int i = 0; i < expq.size() && i < wlog.size(); i++) begin
         nCmp++;
         if (wlog[i] !== expq[i]) begin nBad++; $display("FAIL prio_write%0d: got %h expected %h", i, wlog[i], expq[i]); end
      end
   endtask

   task automatic test_full();
      localparam int NL = 8;
      localparam int NA = 3;
      logic [36:0] aluSeen [$];
      logic [36:0] ldSeen [$];
      int li = 0, ai = 0;
      logic ldGo = 1'b0, aluGo = 1'b0, done = 1'b0;
      logic prevAluReady = 1'b1, fullChecked = 1'b0, seenA0 = 1'b0;
      wlog.delete();
      for (int c = 0; c < 200 && !done; c++) begin
         step();
         if (bus.WriteEnable === 1'b1 && {bus.WriteAddr, bus.WriteData} === {5'd20, 32'hA000_0000}) begin
            seenA0 = 1'b1;
            nCmp++; if (prevAluReady !== 1'b0) begin nBad++; $display("FAIL full_pop_ready: got %b expected 0", prevAluReady); end
            nCmp++; if (ai != 2) begin nBad++; $display("FAIL full_pop_accepts: got %0d expected 2", ai); end
         end
         if (ldGo) li++;
         if (aluGo) ai++;
         if (ai == 2 && !fullChecked) begin
            fullChecked = 1'b1;
            nCmp++; if (bus.alu_ready !== 1'b0) begin nBad++; $display("FAIL full_alu_ready: got %b expected 0", bus.alu_ready); end
            nCmp++; if (bus.ld_ready !== 1'b1) begin nBad++; $display("FAIL full_ld_ready: got %b expected 1", bus.ld_ready); end
         end
         if (li == NL && ai == NA && bus.busy === 1'b0) done = 1'b1;
         bus.ld_valid  = (li < NL);
         bus.ld_addr   = 5'(li + 1);
         bus.ld_data   = 32'h1000_0000 + 32'(li);
         bus.alu_valid = (c >= 1) && (ai < NA);
         bus.alu_addr  = 5'(20 + ai);
         bus.alu_data  = 32'hA000_0000 + 32'(ai);
         ldGo  = bus.ld_valid && bus.ld_ready;
         aluGo = bus.alu_valid && bus.alu_ready;
         prevAluReady = bus.alu_ready;
      end
      idle_inputs();
      nCmp++; if (!done) begin nBad++; $display("FAIL full_timeout: got li=%0d ai=%0d expected %0d/%0d drained", li, ai, NL, NA); end
      nCmp++; if (!seenA0) begin nBad++; $display("FAIL full_a0_written: got 0 expected 1"); end
      foreach (wlog[i]) begin
         if (wlog[i][31:28] == 4'hA) aluSeen.push_back(wlog[i]);
         else ldSeen.push_back(wlog[i]);
      end
      nCmp++; if (aluSeen.size() != NA) begin nBad++; $display("FAIL full_alu_count: got %0d expected %0d", aluSeen.size(), NA); end
      nCmp++; if (ldSeen.size() != NL) begin nBad++; $display("FAIL full_ld_count: got %0d expected %0d", ldSeen.size(), NL); end
      for (int i = 0; i < NA && i < aluSeen.size(); i++) begin
         nCmp++;
         if (aluSeen[i] !== {5'(20 + i), 32'hA000_0000 + 32'(i)}) begin
            nBad++; $display("FAIL full_alu_order%0d: got %h expected %h", i, aluSeen[i], {5'(20 + i), 32'hA000_0000 + 32'(i)});
         end
      end
      for (int i = 0; i < NL && i < ldSeen.size(); i++) begin
         nCmp++;
         if (ldSeen[i] !== {5'(i + 1), 32'h1000_0000 + 32'(i)}) begin
            nBad++; $display("FAIL full_ld_order%0d: got %h expected %h", i, ldSeen[i], {5'(i + 1), 32'h1000_0000 + 32'(i)});
         end
      end
   endtask

   task automatic test_r31();
      logic [36:0] expq [$];
      logic drained = 1'b0;
      wlog.delete();
`ifndef WB_R31_FILTER_EN
      expq.push_back({5'd31, 32'h3131_3131});
`endif
      expq.push_back({5'd5, 32'h0000_5555});
      bus.alu_valid = 1'b1;
      bus.alu_addr  = 5'd31;
      bus.alu_data  = 32'h3131_3131;
      step();
      bus.alu_addr  = 5'd5;
      bus.alu_data  = 32'h0000_5555;
      step();
      bus.alu_valid = 1'b0;
      for (int c = 0; c < 10 && !drained; c++) begin
         step();
         if (bus.busy === 1'b0) drained = 1'b1;
      end
      nCmp++; if (!drained) begin nBad++; $display("FAIL r31_drain: got busy=%b expected 0", bus.busy); end
      nCmp++; if (wlog.size() != expq.size()) begin nBad++; $display("FAIL r31_count: got %0d expected %0d", wlog.size(), expq.size()); end
      for (int i = 0; i < expq.size() && i < wlog.size(); i++) begin
         nCmp++;
         if (wlog[i] !== expq[i]) begin nBad++; $display("FAIL r31_write%0d: got %h expected %h", i, wlog[i], expq[i]); end
      end
   endtask

   task automatic test_reset_mid();
      wlog.delete();
      for (int i = 0; i < 3; i++) begin
         bus.ld_valid  = 1'b1;
         bus.ld_addr   = 5'(7 + i);
         bus.ld_data   = 32'h2000_0000 + 32'(i);
         bus.alu_valid = 1'b1;
         bus.alu_addr  = 5'(25 + i);
         bus.alu_data  = 32'hB000_0000 + 32'(i);
         step();
      end
      nCmp++; if (bus.alu_ready !== 1'b0) begin nBad++; $display("FAIL rmid_alu_full: got %b expected 0", bus.alu_ready); end
      idle_inputs();
      reset = 1'b1;
      step();
      nCmp++; if (bus.WriteEnable !== 1'b0) begin nBad++; $display("FAIL rmid_we: got %b expected 0", bus.WriteEnable); end
      nCmp++; if (bus.alu_ready !== 1'b0) begin nBad++; $display("FAIL rmid_alu_ready: got %b expected 0", bus.alu_ready); end
      nCmp++; if (bus.ld_ready !== 1'b0) begin nBad++; $display("FAIL rmid_ld_ready: got %b expected 0", bus.ld_ready); end
      step();
      nCmp++; if (bus.WriteAddr !== 5'd0) begin nBad++; $display("FAIL rmid_addr: got %h expected 00", bus.WriteAddr); end
      nCmp++; if (bus.WriteData !== 32'd0) begin nBad++; $display("FAIL rmid_data: got %h expected 0", bus.WriteData); end
      reset = 1'b0;
      step();
      nCmp++; if (bus.busy !== 1'b0) begin nBad++; $display("FAIL rmid_busy: got %b expected 0", bus.busy); end
      nCmp++; if (bus.alu_ready !== 1'b1) begin nBad++; $display("FAIL rmid_alu_ready_after: got %b expected 1", bus.alu_ready); end
      step();
      step();
      step();
      nCmp++; if (wlog.size() != 2) begin nBad++; $display("FAIL rmid_count: got %0d expected 2", wlog.size()); end
      if (wlog.size() >= 2) begin
         nCmp++; if (wlog[0] !== {5'd7, 32'h2000_0000}) begin nBad++; $display("FAIL rmid_write0: got %h expected %h", wlog[0], {5'd7, 32'h2000_0000}); end
         nCmp++; if (wlog[1] !== {5'd8, 32'h2000_0001}) begin nBad++; $display("FAIL rmid_write1: got %h expected %h", wlog[1], {5'd8, 32'h2000_0001}); end
      end
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_single();
      test_priority();
      test_full();
      test_r31();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish before 200000");
      $fatal(1);
   end

endmodule
